asap2_core: RTL and testbench

- Parametrised, single-module successor to the asap1 CPU. Contains the full datapath: A and B registers, PC, MAR, IR, flags, ALU, RAM and output port.
- Generalises data and address width over asap1.
- Adds a run/single-step control, a program-load port, HLT, and a valid/ready handshake on the output port.
- Intended as the core instantiated by the next board top.

---
 rtl/asap2_pkg.sv | 28 ++
 rtl/asap2_alu.sv | 25 ++
 rtl/asap2_core.sv | 189 ++++++++++++++++++
 tb/tb_asap2_core.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asap2_pkg.sv
// Shared opcode values, T-state encodings and field widths for the asap2 core.
package asap2_pkg;

    // Width of the opcode field at the top of every instruction word.
    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
    localparam logic [OPC_W-1:0] OP_STA = 4'h4;
    localparam logic [OPC_W-1:0] OP_LDI = 4'h5;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h6;
    localparam logic [OPC_W-1:0] OP_JC  = 4'h7;
    localparam logic [OPC_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
    localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

    // T-state sequence: T0/T1 fetch, T2..T4 execute.
    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } tstate_t;

endpackage

// File: rtl/asap2_alu.sv
// Combinational add/subtract unit; result and flags are registered by the core.
module asap2_alu #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              sub_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o,
    output logic              zero_o
);

    logic [DATA_W-1:0] b_op;
    logic [DATA_W:0]   sum;

    // Subtraction is A + ~B + 1, so carry out = 1 means no borrow (A >= B).
    always_comb begin
        b_op     = sub_i ? ~b_i : b_i;
        sum      = {1'b0, a_i} + {1'b0, b_op} + {{DATA_W{1'b0}}, sub_i};
        result_o = sum[DATA_W-1:0];
        carry_o  = sum[DATA_W];
        zero_o   = (sum[DATA_W-1:0] == '0);
    end

endmodule

// File: rtl/asap2_core.sv
// asap2 CPU core: fetch/execute FSM, A/B/PC/MAR/IR registers, flags, RAM and
// a valid/ready output port.
// Output port handshake: out_data is offered while out_valid=1; a transfer
// happens on a rising clk edge where out_valid && out_ready, after which
// out_valid drops and out_data keeps its value; out_ready alone is ignored.
module asap2_core
    import asap2_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              zf,
    output logic              cf,
    output logic [2:0]        tstate
);

    localparam int DEPTH = 1 << ADDR_W;

    tstate_t           tstate_q, tstate_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, ir_q, ir_d;
    logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
    logic              zf_q, zf_d, cf_q, cf_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d, halted_q, halted_d;
    logic              sta_we;
    logic [DATA_W-1:0] ram_q [DEPTH];

    logic              adv, prog_wr;
    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] ram_rd;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c, alu_z;

    assign adv     = run | step;
    assign opcode  = ir_q[DATA_W-1 -: OPC_W];
    assign operand = ir_q[ADDR_W-1:0];
    assign ram_rd  = ram_q[mar_q];
    // Program loads only while the core is paused or halted, never alongside STA.
    assign prog_wr = prog_we && (!adv || halted_q);

    asap2_alu #(.DATA_W(DATA_W)) u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .sub_i    (opcode == OP_SUB),
        .result_o (alu_res),
        .carry_o  (alu_c),
        .zero_o   (alu_z)
    );

    // Next-state and datapath updates for every T-state of every opcode.
    always_comb begin
        tstate_d    = tstate_q;
        a_d         = a_q;
        b_d         = b_q;
        ir_d        = ir_q;
        pc_d        = pc_q;
        mar_d       = mar_q;
        zf_d        = zf_q;
        cf_d        = cf_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        halted_d    = halted_q;
        sta_we      = 1'b0;
        if (halted_q) begin
            // HLT freezes the FSM until reset.
        end else if (tstate_q == T3 && opcode == OP_OUT) begin
            // Output stall does not depend on run/step.
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
                tstate_d    = T0;
            end
        end else if (adv) begin
            tstate_d = T0;
            case (tstate_q)
                T0: begin
                    mar_d    = pc_q;
                    tstate_d = T1;
                end
                T1: begin
                    ir_d     = ram_rd;
                    pc_d     = pc_q + 1'b1;
                    tstate_d = T2;
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            mar_d    = operand;
                            tstate_d = T3;
                        end
                        OP_LDI: a_d = {{(DATA_W-ADDR_W){1'b0}}, operand};
                        OP_JMP: pc_d = operand;
                        OP_JC:  if (cf_q) pc_d = operand;
                        OP_JZ:  if (zf_q) pc_d = operand;
                        OP_OUT: begin
                            out_data_d  = a_q;
                            out_valid_d = 1'b1;
                            tstate_d    = T3;
                        end
                        OP_HLT: halted_d = 1'b1;
                        OP_NOP: tstate_d = T0;
                        default: tstate_d = T0;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_LDA: a_d = ram_rd;
                        OP_ADD, OP_SUB: begin
                            b_d      = ram_rd;
                            tstate_d = T4;
                        end
                        OP_STA: sta_we = 1'b1;
                        default: tstate_d = T0;
                    endcase
                end
                T4: begin
                    a_d  = alu_res;
                    cf_d = alu_c;
                    zf_d = alu_z;
                end
                default: tstate_d = T0;
            endcase
        end
    end

    // T-state register.
    always_ff @(posedge clk) begin
        if (!rst) tstate_q <= T0;
        else      tstate_q <= tstate_d;
    end

    // Datapath, flag and output-port registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q         <= '0;
            b_q         <= '0;
            ir_q        <= '0;
            pc_q        <= '0;
            mar_q       <= '0;
            zf_q        <= 1'b0;
            cf_q        <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            ir_q        <= ir_d;
            pc_q        <= pc_d;
            mar_q       <= mar_d;
            zf_q        <= zf_d;
            cf_q        <= cf_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
        end
    end

    // RAM write port; contents survive reset so a loaded program can be rerun.
    always_ff @(posedge clk) begin
        if (sta_we && rst) ram_q[mar_q] <= a_q;
        else if (prog_wr)  ram_q[prog_addr] <= prog_data;
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = halted_q;
    assign pc        = pc_q;
    assign a         = a_q;
    assign b         = b_q;
    assign zf        = zf_q;
    assign cf        = cf_q;
    assign tstate    = tstate_q;

endmodule

// File: tb/tb_asap2_core.sv
// Directed bench for asap2_core: hand-computed expectations, output-port
// scoreboard with an expected queue and a separate monitor.
module tb_asap2_core;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              run = 1'b0;
    logic              step = 1'b0;
    logic              prog_we = 1'b0;
    logic [ADDR_W-1:0] prog_addr = '0;
    logic [DATA_W-1:0] prog_data = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              halted;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              zf;
    logic              cf;
    logic [2:0]        tstate;

    logic [DATA_W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    asap2_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .step      (step),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .halted    (halted),
        .pc        (pc),
        .a         (a),
        .b         (b),
        .zf        (zf),
        .cf        (cf),
        .tstate    (tstate)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] d);
        prog_we   = 1'b1;
        prog_addr = ad;
        prog_data = d;
        tick(1);
        prog_we   = 1'b0;
    endtask

    task automatic clear_ram();
        run  = 1'b0;
        step = 1'b0;
        for (int i = 0; i < (1 << ADDR_W); i++) load(i[ADDR_W-1:0], '0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int i = 0;
        while (!out_valid && i < budget) begin
            tick(1);
            i++;
        end
        chk(name, {31'd0, out_valid}, 32'd1);
    endtask

    // Runs until halted, counting cycles spent in T4 (ADD/SUB result states).
    task automatic run_to_halt(input string name, input int budget, output int t4_cnt);
        int i = 0;
        t4_cnt = 0;
        run = 1'b1;
        while (!halted && i < budget) begin
            tick(1);
            if (tstate == 3'd4) t4_cnt++;
            i++;
        end
        run = 1'b0;
        chk(name, {31'd0, halted}, 32'd1);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL out_unexpected: got 0x%0h, expected no transfer", out_data);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_err++;
                    $display("FAIL out_data: got 0x%0h, expected 0x%0h", out_data, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic load_add_prog();
        clear_ram();
        load(4'd0, 8'h1E);   // LDA 14
        load(4'd1, 8'h2F);   // ADD 15
        load(4'd2, 8'hE0);   // OUT
        load(4'd3, 8'hF0);   // HLT
        load(4'd14, 8'd28);
        load(4'd15, 8'd14);
    endtask

    task automatic arith(input string name, input logic [DATA_W-1:0] op0,
                         input logic [DATA_W-1:0] op1, input logic [DATA_W-1:0] m14,
                         input logic [DATA_W-1:0] m15, input logic [DATA_W-1:0] exp_a,
                         input logic exp_cf, input logic exp_zf);
        int t4;
        clear_ram();
        load(4'd0, op0);
        load(4'd1, op1);
        load(4'd2, 8'hF0);
        load(4'd14, m14);
        load(4'd15, m15);
        do_reset();
        run_to_halt({name, "_halt"}, 100, t4);
        chk({name, "_a"}, {24'd0, a}, {24'd0, exp_a});
        chk({name, "_cf"}, {31'd0, cf}, {31'd0, exp_cf});
        chk({name, "_zf"}, {31'd0, zf}, {31'd0, exp_zf});
    endtask

    initial begin
        int t4;

        // Reset state
        rst = 1'b0;
        tick(2);
        chk("rst_pc", {28'd0, pc}, 32'd0);
        chk("rst_a", {24'd0, a}, 32'd0);
        chk("rst_b", {24'd0, b}, 32'd0);
        chk("rst_tstate", {29'd0, tstate}, 32'd0);
        chk("rst_flags", {30'd0, zf, cf}, 32'd0);
        chk("rst_out", {23'd0, out_valid, out_data}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        rst = 1'b1;

        // Add and output with backpressure: 28 + 14 = 42
        load_add_prog();
        do_reset();
        out_ready = 1'b0;
        exp_q.push_back(8'd42);
        run = 1'b1;
        wait_valid("add_valid", 50);
        chk("add_outdata", {24'd0, out_data}, 32'd42);
        tick(5);
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_pc", {28'd0, pc}, 32'd3);
        chk("stall_tstate", {29'd0, tstate}, 32'd3);
        out_ready = 1'b1;
        run_to_halt("add_halt", 50, t4);
        chk("add_flags", {30'd0, zf, cf}, 32'd0);
        chk("add_pc", {28'd0, pc}, 32'd4);
        chk("add_outhold", {23'd0, out_valid, out_data}, 32'd42);

        // SUB / ADD flags
        arith("sub_borrow", 8'h55, 8'h3E, 8'd7, 8'd0, 8'hFE, 1'b0, 1'b0);
        chk("sub_borrow_b", {24'd0, b}, 32'd7);
        arith("sub_equal", 8'h57, 8'h3E, 8'd7, 8'd0, 8'h00, 1'b1, 1'b1);
        arith("add_carry", 8'h1E, 8'h2F, 8'd200, 8'd100, 8'd44, 1'b1, 1'b0);
        arith("add_wrap0", 8'h1E, 8'h2F, 8'd128, 8'd128, 8'd0, 1'b1, 1'b1);

        // Conditional loop: LDI 3; L: SUB 15; JZ 5; JMP L; 5: OUT; HLT
        clear_ram();
        load(4'd0, 8'h53);
        load(4'd1, 8'h3F);
        load(4'd2, 8'h85);
        load(4'd3, 8'h61);
        load(4'd5, 8'hE0);
        load(4'd6, 8'hF0);
        load(4'd15, 8'd1);
        do_reset();
        out_ready = 1'b1;
        exp_q.push_back(8'd0);
        run_to_halt("loop_halt", 300, t4);
        chk("loop_sub_count", t4, 32'd3);
        chk("loop_a", {24'd0, a}, 32'd0);
        chk("loop_zf", {31'd0, zf}, 32'd1);
        chk("loop_pc", {28'd0, pc}, 32'd7);

        // Single-step through LDA 14
        load_add_prog();
        do_reset();
        step = 1'b1; tick(1); step = 1'b0;
        chk("step1_t", {29'd0, tstate}, 32'd1);
        chk("step1_pc", {28'd0, pc}, 32'd0);
        step = 1'b1; tick(1); step = 1'b0;
        chk("step2_t", {29'd0, tstate}, 32'd2);
        chk("step2_pc", {28'd0, pc}, 32'd1);
        step = 1'b1; tick(1); step = 1'b0;
        chk("step3_t", {29'd0, tstate}, 32'd3);
        tick(4);
        chk("step_hold_t", {29'd0, tstate}, 32'd3);
        chk("step_hold_a", {24'd0, a}, 32'd0);
        step = 1'b1; tick(1); step = 1'b0;
        chk("step4_t", {29'd0, tstate}, 32'd0);
        chk("step4_a", {24'd0, a}, 32'd28);

        // PC wrap (0: NOP, 1: JMP 15, 15: NOP) and dropped program write
        clear_ram();
        load(4'd1, 8'h6F);
        load(4'd5, 8'h33);
        do_reset();
        run = 1'b1;
        prog_we = 1'b1; prog_addr = 4'd5; prog_data = 8'hAA;
        tick(6);
        chk("wrap_pc15", {28'd0, pc}, 32'd15);
        tick(2);
        chk("wrap_pc0", {28'd0, pc}, 32'd0);
        prog_we = 1'b0;
        run = 1'b0;
        load(4'd0, 8'h15);   // LDA 5
        load(4'd1, 8'hF0);   // HLT
        do_reset();
        run_to_halt("gate_halt", 50, t4);
        chk("gate_ram5", {24'd0, a}, 32'h33);

        // Reset in the middle of an OUT handshake, then rerun
        load_add_prog();
        do_reset();
        out_ready = 1'b0;
        run = 1'b1;
        wait_valid("mid_valid", 50);
        rst = 1'b0;
        tick(1);
        chk("mid_rst_out", {23'd0, out_valid, out_data}, 32'd0);
        chk("mid_rst_pc", {28'd0, pc}, 32'd0);
        chk("mid_rst_t", {29'd0, tstate}, 32'd0);
        rst = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back(8'd42);
        run_to_halt("rerun_halt", 80, t4);
        chk("rerun_a", {24'd0, a}, 32'd42);

        tick(2);
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
